// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the sequential floating-point engines.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MULTIPLY,
    NORMALIZE,
    ROUND,
    PACK,
    DONE
  } state_t;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int FP32_BIAS = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction; a carry out bumps the exponent.
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int XW = 10
) (
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  input  logic [XW-1:0]     exp,
  output logic [FRAC_W-1:0] frac_out,
  output logic [XW-1:0]     exp_out
);

  logic [FRAC_W:0] sum;

  // On carry out the low bits are already zero, which is the required frac=0.
  always_comb begin
    sum      = {1'b0, frac} + {{FRAC_W{1'b0}}, guard & (sticky | frac[0])};
    frac_out = sum[FRAC_W-1:0];
    exp_out  = exp + XW'(sum[FRAC_W]);
  end

endmodule

// File: rtl/fp_mul_shift_add_fsm_32bit.sv
// Sequential FP32 multiplier using iterative shift-add with a start/done handshake.
// Define FP_MUL_SPECIALS_EN to detect zero/denormal/inf/NaN and saturate/flush the exponent.
module fp_mul_shift_add_fsm_32bit #(
  parameter int BIAS          = 127,
  parameter int BITS_PER_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done
);
  import fp_pkg::*;

  localparam int STEPS = 24 / BITS_PER_STEP;
`ifdef FP_MUL_SPECIALS_EN
  localparam int XW = 10;
`else
  // Without specials the exponent wraps mod 256, so 8 bits carry the whole result.
  localparam int XW = 8;
`endif

  state_t              state;
  logic [23:0]         ma;
  logic [23:0]         mb;
  logic [47:0]         prod;
  logic [47:0]         partial;
  logic                sign;
  logic [XW-1:0]       exp_sum;
  logic [XW-1:0]       exp_n;
  logic [XW-1:0]       exp_r;
  logic [XW-1:0]       exp_rnd;
  logic [4:0]          count;
  logic [FRAC_W-1:0]   frac_n;
  logic [FRAC_W-1:0]   frac_r;
  logic [FRAC_W-1:0]   frac_rnd;
  logic                guard;
  logic                sticky;

  always_comb begin
    partial = 48'(ma) * 48'(mb[BITS_PER_STEP-1:0]);
  end

  fp_round_rne #(.XW(XW)) u_round (
    .frac     (frac_n),
    .guard    (guard),
    .sticky   (sticky),
    .exp      (exp_n),
    .frac_out (frac_rnd),
    .exp_out  (exp_rnd)
  );

`ifdef FP_MUL_SPECIALS_EN
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, op_sign;

  always_comb begin
    a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero  = (a[30:23] == 8'h00);
    b_zero  = (b[30:23] == 8'h00);
    op_sign = a[31] ^ b[31];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ma      <= '0;
      mb      <= '0;
      prod    <= '0;
      sign    <= 1'b0;
      exp_sum <= '0;
      exp_n   <= '0;
      exp_r   <= '0;
      count   <= '0;
      frac_n  <= '0;
      frac_r  <= '0;
      guard   <= 1'b0;
      sticky  <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= UNPACK;
        end
        UNPACK: begin
          ma      <= {1'b1, a[22:0]};
          mb      <= {1'b1, b[22:0]};
          sign    <= a[31] ^ b[31];
          exp_sum <= XW'({2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'(BIAS));
          prod    <= '0;
          count   <= '0;
          state   <= MULTIPLY;
`ifdef FP_MUL_SPECIALS_EN
          // Special operands bypass the datapath and complete immediately.
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result <= QNAN;
            done   <= 1'b1;
            state  <= DONE;
          end else if (a_inf || b_inf) begin
            result <= {op_sign, POS_INF[30:0]};
            done   <= 1'b1;
            state  <= DONE;
          end else if (a_zero || b_zero) begin
            result <= {op_sign, 31'd0};
            done   <= 1'b1;
            state  <= DONE;
          end
`endif
        end
        MULTIPLY: begin
          prod  <= prod + (partial << (int'(count) * BITS_PER_STEP));
          mb    <= mb >> BITS_PER_STEP;
          count <= count + 5'd1;
          if (count == 5'(STEPS - 1)) state <= NORMALIZE;
        end
        NORMALIZE: begin
          if (prod[47]) begin
            frac_n <= prod[46:24];
            guard  <= prod[23];
            sticky <= |prod[22:0];
            exp_n  <= exp_sum + XW'(1);
          end else begin
            frac_n <= prod[45:23];
            guard  <= prod[22];
            sticky <= |prod[21:0];
            exp_n  <= exp_sum;
          end
          state <= ROUND;
        end
        ROUND: begin
          frac_r <= frac_rnd;
          exp_r  <= exp_rnd;
          state  <= PACK;
        end
        PACK: begin
`ifdef FP_MUL_SPECIALS_EN
          if ($signed(exp_r) >= $signed(10'd255)) begin
            result <= {sign, POS_INF[30:0]};
          end else if ($signed(exp_r) < $signed(10'd1)) begin
            result <= {sign, 31'd0};
          end else begin
            result <= {sign, exp_r[7:0], frac_r};
          end
`else
          result <= {sign, exp_r, frac_r};
`endif
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
